// File: rtl/light_sequence_monitor.sv
// Passive lamp-pattern checker: decodes intersection state, tracks dwell,
// and latches the first encoding/conflict/sequence/dwell violation.
module light_sequence_monitor #(
  parameter int MIN_G = 4,
  parameter int MIN_Y = 3,
  parameter int DW_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             R,
  input  logic             EN,
  input  logic             NR,
  input  logic             NG,
  input  logic             NY,
  input  logic             ER,
  input  logic             EG,
  input  logic             EY,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [2:0]       obs_state,
  output logic [DW_W-1:0]  dwell,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    S_NG  = 3'd1,
    S_NY  = 3'd2,
    S_AR  = 3'd3,
    S_EG  = 3'd4,
    S_EY  = 3'd5,
    S_BAD = 3'd7
  } st_t;

  localparam logic [DW_W-1:0] MIN_G_W = DW_W'(MIN_G);
  localparam logic [DW_W-1:0] MIN_Y_W = DW_W'(MIN_Y);

  st_t              state_q, state_d, dec;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;

  logic             oh_bad, conflict, good, leave, legal;
  logic             y_short, g_short;
  logic [2:0]       code_now;

  always_comb begin
    oh_bad   = !$onehot({NR, NG, NY}) || !$onehot({ER, EG, EY});
    conflict = (NG | NY) & (EG | EY);
    case ({NR, NG, NY, ER, EG, EY})
      6'b010_100: dec = S_NG;
      6'b001_100: dec = S_NY;
      6'b100_100: dec = S_AR;
      6'b100_010: dec = S_EG;
      6'b100_001: dec = S_EY;
      default:    dec = S_BAD;
    endcase
  end

  always_comb begin
    good  = (state_q != INIT) && (state_q != S_BAD);
    leave = good && (dec != state_q);
    case (state_q)
      S_NG:    legal = (dec == S_NY);
      S_NY:    legal = (dec == S_AR) || (dec == S_EG);
      S_AR:    legal = (dec == S_NG) || (dec == S_EG);
      S_EG:    legal = (dec == S_EY);
      S_EY:    legal = (dec == S_AR) || (dec == S_NG);
      default: legal = 1'b0;
    endcase
    y_short = leave && (state_q == S_NY || state_q == S_EY)
              && (dwell_q < MIN_Y_W);
    g_short = leave && (state_q == S_NG || state_q == S_EG)
              && (dwell_q < MIN_G_W);
    if (oh_bad)              code_now = 3'd1;
    else if (conflict)       code_now = 3'd2;
    else if (leave && !legal) code_now = 3'd3;
    else if (y_short)        code_now = 3'd4;
    else if (g_short)        code_now = 3'd5;
    else                     code_now = 3'd0;
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    err_d   = err_q;
    code_d  = code_q;
    if (EN) begin
      state_d = dec;
      if (dec == state_q)
        dwell_d = (&dwell_q) ? dwell_q : dwell_q + 1'b1;
      else
        dwell_d = {{(DW_W-1){1'b0}}, 1'b1};
      // only the first violation is kept
      if (!err_q && code_now != 3'd0) begin
        err_d  = 1'b1;
        code_d = code_now;
      end
      if (dec == S_EG && state_q != S_EG)
        seen_d = 1'b1;
      if (dec == S_NG && state_q != S_NG && seen_q) begin
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        seen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= INIT;
      dwell_q <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign err       = err_q;
  assign err_code  = code_q;
  assign obs_state = state_q;
  assign dwell     = dwell_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Scoreboard bench for light_sequence_monitor: a lamp-level reference
// model predicts every output, plus scenario-end checks against constants.
module tb_light_sequence_monitor;

  localparam logic [5:0] L_NG = 6'b010_100;
  localparam logic [5:0] L_NY = 6'b001_100;
  localparam logic [5:0] L_AR = 6'b100_100;
  localparam logic [5:0] L_EG = 6'b100_010;
  localparam logic [5:0] L_EY = 6'b100_001;

  logic        clk = 1'b0;
  logic        R = 1'b1;
  logic        EN = 1'b0;
  logic        NR = 1'b0, NG = 1'b0, NY = 1'b0;
  logic        ER = 1'b0, EG = 1'b0, EY = 1'b0;
  logic        err;
  logic [2:0]  err_code;
  logic [2:0]  obs_state;
  logic [7:0]  dwell;
  logic [15:0] cycle_cnt;

  light_sequence_monitor #(
    .MIN_G(4), .MIN_Y(3), .DW_W(8), .CNT_W(16)
  ) dut (
    .clk(clk), .R(R), .EN(EN),
    .NR(NR), .NG(NG), .NY(NY),
    .ER(ER), .EG(EG), .EY(EY),
    .err(err), .err_code(err_code),
    .obs_state(obs_state), .dwell(dwell),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [2:0]  code;
    logic [2:0]  st;
    logic [7:0]  dw;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  int   m_st, m_dw, m_cnt, m_code;
  bit   m_err, m_seen;
  bit   legal [8][8];
  int   st_map [3][3];

  initial begin
    foreach (legal[i, j]) legal[i][j] = 1'b0;
    legal[1][2] = 1; legal[2][3] = 1; legal[2][4] = 1;
    legal[3][1] = 1; legal[3][4] = 1; legal[4][5] = 1;
    legal[5][3] = 1; legal[5][1] = 1;
    // index: 0 red, 1 green, 2 yellow  [north][east]
    foreach (st_map[i, j]) st_map[i][j] = 7;
    st_map[0][0] = 3; st_map[1][0] = 1; st_map[2][0] = 2;
    st_map[0][1] = 4; st_map[0][2] = 5;
  end

  function automatic int lamp_idx(input logic r, input logic g);
    return r ? 0 : (g ? 1 : 2);
  endfunction

  task automatic model(input logic [5:0] l, input bit en, input bit rst);
    int nn, ne, d, c;
    bit good;
    nn = int'(l[5]) + int'(l[4]) + int'(l[3]);
    ne = int'(l[2]) + int'(l[1]) + int'(l[0]);
    if (rst) begin
      m_st = 0; m_dw = 0; m_cnt = 0; m_code = 0;
      m_err = 0; m_seen = 0;
      return;
    end
    if (!en) return;
    c = 0;
    if (nn != 1 || ne != 1) begin
      d = 7; c = 1;
    end else if ((l[4] | l[3]) & (l[1] | l[0])) begin
      d = 7; c = 2;
    end else begin
      d = st_map[lamp_idx(l[5], l[4])][lamp_idx(l[2], l[1])];
    end
    good = (m_st != 0) && (m_st != 7);
    if (c == 0 && good && d != m_st) begin
      if (!legal[m_st][d]) c = 3;
      else if ((m_st == 2 || m_st == 5) && m_dw < 3) c = 4;
      else if ((m_st == 1 || m_st == 4) && m_dw < 4) c = 5;
    end
    if (!m_err && c != 0) begin
      m_err = 1; m_code = c;
    end
    if (d == 4 && m_st != 4) m_seen = 1;
    if (d == 1 && m_st != 1 && m_seen) begin
      if (m_cnt < 65535) m_cnt++;
      m_seen = 0;
    end
    if (d == m_st) begin
      if (m_dw < 255) m_dw++;
    end else begin
      m_dw = 1;
    end
    m_st = d;
  endtask

  task automatic step(input logic [5:0] l, input bit en, input bit rst);
    exp_t e;
    @(negedge clk);
    {NR, NG, NY, ER, EG, EY} = l;
    EN = en;
    R  = rst;
    model(l, en, rst);
    e.err = m_err; e.code = 3'(m_code); e.st = 3'(m_st);
    e.dw = 8'(m_dw); e.cnt = 16'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    step(L_AR, 1'b0, 1'b1);
  endtask

  // scoreboard consumer: compares every predicted cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({err, err_code, obs_state, dwell, cycle_cnt} !==
            {e.err, e.code, e.st, e.dw, e.cnt}) begin
          n_fail++;
          $display("FAIL sb t=%0t got err=%b code=%0d st=%0d dw=%0d cnt=%0d want err=%b code=%0d st=%0d dw=%0d cnt=%0d",
                   $time, err, err_code, obs_state, dwell, cycle_cnt,
                   e.err, e.code, e.st, e.dw, e.cnt);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({err, err_code, obs_state, dwell, cycle_cnt} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset got %b required 0",
               {err, err_code, obs_state, dwell, cycle_cnt});
    end
  endtask

  task automatic test_legal_loop();
    do_reset();
    hold(L_NG, 4); hold(L_NY, 3); hold(L_EG, 4); hold(L_EY, 3);
    hold(L_NG, 1);
    n_checks++;
    if ({err, cycle_cnt, obs_state, dwell} !== {1'b0, 16'd1, 3'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL legal_loop got err=%b cnt=%0d st=%0d dw=%0d required 0/1/1/1",
               err, cycle_cnt, obs_state, dwell);
    end
  endtask

  task automatic test_yellow_short();
    do_reset();
    hold(L_NG, 4); hold(L_NY, 2);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL y_short_pre got err=%b required 0", err);
    end
    hold(L_EG, 1);
    n_checks++;
    if ({err, err_code} !== {1'b1, 3'd4}) begin
      n_fail++;
      $display("FAIL y_short got err=%b code=%0d required 1/4", err, err_code);
    end
  endtask

  task automatic test_green_short();
    do_reset();
    hold(L_NY, 3); hold(L_EG, 3); hold(L_EY, 1);
    n_checks++;
    if ({err, err_code} !== {1'b1, 3'd5}) begin
      n_fail++;
      $display("FAIL g_short got err=%b code=%0d required 1/5", err, err_code);
    end
  endtask

  task automatic test_illegal_jump();
    do_reset();
    hold(L_NG, 5); hold(L_AR, 1);
    n_checks++;
    if (err_code !== 3'd3) begin
      n_fail++;
      $display("FAIL illegal_jump got code=%0d required 3", err_code);
    end
    hold(L_AR, 2); hold(L_NG, 2); hold(L_NY, 1);
    hold(L_NG, 4); hold(L_NY, 3); hold(L_EG, 4);
    n_checks++;
    if ({err_code, obs_state} !== {3'd3, 3'd4}) begin
      n_fail++;
      $display("FAIL sticky got code=%0d st=%0d required 3/4",
               err_code, obs_state);
    end
  endtask

  task automatic test_conflict_onehot();
    do_reset();
    hold(6'b010_010, 1);
    n_checks++;
    if ({err_code, obs_state} !== {3'd2, 3'd7}) begin
      n_fail++;
      $display("FAIL conflict got code=%0d st=%0d required 2/7",
               err_code, obs_state);
    end
    do_reset();
    hold(6'b110_000, 1);
    n_checks++;
    if (err_code !== 3'd1) begin
      n_fail++;
      $display("FAIL onehot got code=%0d required 1", err_code);
    end
    hold(L_EY, 2);
    n_checks++;
    if ({err_code, obs_state, dwell} !== {3'd1, 3'd5, 8'd2}) begin
      n_fail++;
      $display("FAIL recover got code=%0d st=%0d dw=%0d required 1/5/2",
               err_code, obs_state, dwell);
    end
  endtask

  task automatic test_en_freeze();
    do_reset();
    hold(L_NG, 2);
    for (int i = 0; i < 10; i++)
      step((i % 2) ? 6'b010_010 : L_AR, 1'b0, 1'b0);
    n_checks++;
    if ({err, obs_state, dwell} !== {1'b0, 3'd1, 8'd2}) begin
      n_fail++;
      $display("FAIL freeze got err=%b st=%0d dw=%0d required 0/1/2",
               err, obs_state, dwell);
    end
    hold(L_NG, 2);
    n_checks++;
    if (dwell !== 8'd4) begin
      n_fail++;
      $display("FAIL freeze_dwell got %0d required 4", dwell);
    end
    hold(L_NY, 1);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_noerr got err=%b code=%0d required 0",
               err, err_code);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      hold(L_NG, 4); hold(L_NY, 3); hold(L_EG, 4); hold(L_EY, 3);
    end
    hold(L_NG, 1); hold(L_AR, 1);
    n_checks++;
    if ({err, cycle_cnt} !== {1'b1, 16'd2}) begin
      n_fail++;
      $display("FAIL mid_pre got err=%b cnt=%0d required 1/2", err, cycle_cnt);
    end
    step(L_AR, 1'b1, 1'b1);
    n_checks++;
    if ({err, err_code, obs_state, dwell, cycle_cnt} !== 30'd0) begin
      n_fail++;
      $display("FAIL mid_reset got %b required 0",
               {err, err_code, obs_state, dwell, cycle_cnt});
    end
    hold(L_EY, 1);
    n_checks++;
    if ({err, obs_state, dwell} !== {1'b0, 3'd5, 8'd1}) begin
      n_fail++;
      $display("FAIL fresh_start got err=%b st=%0d dw=%0d required 0/5/1",
               err, obs_state, dwell);
    end
  endtask

  task automatic test_dwell_sat();
    do_reset();
    hold(L_NG, 260);
    n_checks++;
    if ({err, dwell} !== {1'b0, 8'd255}) begin
      n_fail++;
      $display("FAIL dwell_sat got err=%b dw=%0d required 0/255", err, dwell);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      hold(L_NG, 4); hold(L_NY, 3); hold(L_AR, 2);
      hold(L_EG, 5); hold(L_EY, 3); hold(L_AR, 1);
    end
    hold(L_NG, 1);
    n_checks++;
    if ({err, cycle_cnt} !== {1'b0, 16'd3}) begin
      n_fail++;
      $display("FAIL back_to_back got err=%b cnt=%0d required 0/3",
               err, cycle_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_legal_loop();
    test_yellow_short();
    test_green_short();
    test_illegal_jump();
    test_conflict_onehot();
    test_en_freeze();
    test_reset_mid_run();
    test_dwell_sat();
    test_back_to_back();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d entries required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
